farm_road_vehicle_sensor: RTL and testbench
===========================================

Name: farm_road_vehicle_sensor

Overview:
Generates the farm-road car sensor signal C that feeds the traffic light controller, closing the loop in place of a hand-driven C.
- Counts vehicle arrivals into a waiting queue.
- Drains the queue while the farm-road light is green.
- Holds C high whenever any vehicle is waiting.
- Sits beside the controller in the intersection top level and in benches.
- Also flags illegal light codes and queue overflow.

Parameters:
QW, 4, queue counter width; MAX_Q = 2**QW-1 (15).
START_CYCLES, 4, cycles from green onset to first departure (1..255).
DEPART_CYCLES, 2, cycles between successive departures while green (1..255).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
car_arrive  input  1  one-cycle pulse; one vehicle joins the farm-road queue.
light_farm  input  3  farm-road light from controller, one-hot: 3'b100 red, 3'b010 yellow, 3'b001 green.
C  output  1  registered; 1 when queue_count != 0.
queue_count  output  QW  registered number of waiting vehicles.
car_depart  output  1  registered one-cycle pulse; one vehicle left the queue.
overflow  output  1  sticky; arrival dropped at MAX_Q.
light_err  output  1  sticky; light_farm was not one of the three legal codes.

Behaviour:
Reset and clocking:
- One clock; reset is asynchronous, active-high.
- Asserting rst immediately clears: C, queue_count, car_depart, overflow, light_err, timer; state=IDLE.
- Reset mid-drain discards the queue. No departure pulse is emitted on the edge after release.
- All outputs are registered.

Light decode (sampled each cycle):
- green = (light_farm == 3'b001).
- Any code other than 3'b100, 3'b010, 3'b001 sets light_err and is treated as not-green.

Departure FSM (8-bit down-timer):
- IDLE: wait for green. On a green cycle, go to START with timer = START_CYCLES-1.
- START: decrement timer each green cycle. At timer==0:
  - if count>0, raise dep_req, go to FLOW, timer = DEPART_CYCLES-1;
  - if count==0, go to FLOW with timer = 0.
- FLOW:
  - If count>0: decrement timer; at 0 raise dep_req and reload DEPART_CYCLES-1.
  - If count==0: timer holds at DEPART_CYCLES-1, so a car arriving during green departs DEPART_CYCLES cycles after it is counted.
- Any non-green cycle (red, yellow, illegal) in START or FLOW: return to IDLE and clear timer. The same edge issues no departure.
- Timing consequence: with cars waiting, the first car_depart is high in cycle G+START_CYCLES, where cycle G is the first cycle green is sampled. Later pulses are spaced DEPART_CYCLES apart.

Queue counter, evaluated every edge:
- arrival only, count<MAX_Q: count+1.
- arrival only, count==MAX_Q: count unchanged, set overflow.
- departure only: count-1. dep_req is never raised at count 0, so no underflow.
- arrival and departure in the same cycle: count unchanged, car_depart still pulses, overflow not set.
- car_depart = dep_req, registered on the same edge as the count update.
- C is registered from next-count != 0, so C always equals (queue_count != 0) in the same cycle. C drops on the edge where the last car departs.

Sticky flags:
- overflow and light_err clear only on rst.

Test Plan:
1. Reset then idle: rst pulsed high 2 cycles with light_farm=3'b100, no arrivals -> C=0, queue_count=0, car_depart never high, flags 0.
2. Three arrivals on red -> queue_count 1,2,3 on successive edges; C=1 from the first edge; no departures while red/yellow for 100 cycles.
3. Drain: 3 queued, light_farm->3'b001 at cycle G -> car_depart high at G+4, G+6, G+8; queue_count 2,1,0; C falls with the third pulse.
4. Green cut short: 5 queued; green held 6 cycles, then yellow -> exactly one departure (G+4); queue_count=4; C stays 1. Next green restarts the 4-cycle start delay.
5. Saturation and simultaneity: 16 arrivals on red -> queue_count=15, overflow=1. Then on green, an arrival coincident with the first departure pulse -> queue_count stays 15, car_depart=1.
6. Illegal light and async reset: light_farm=3'b011 for one cycle -> light_err=1, no departures. Then rst asserted between clock edges mid-drain -> all outputs 0 immediately.

Source files
------------

// File: rtl/farm_road_vehicle_sensor.sv
// Farm-road vehicle sensor: counts arriving vehicles, drains them while the
// farm-road light is green, and drives the car sensor C for the controller.
//
// state | meaning
// IDLE  | light not green; waiting for green onset
// START | green seen; timing the start-up delay before the first departure
// FLOW  | green; one departure every DEPART_CYCLES while vehicles wait
module farm_road_vehicle_sensor #(
  parameter int QW            = 4,
  parameter int START_CYCLES  = 4,
  parameter int DEPART_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          car_arrive,
  input  logic [2:0]    light_farm,
  output logic          C,
  output logic [QW-1:0] queue_count,
  output logic          car_depart,
  output logic          overflow,
  output logic          light_err
);

  localparam logic [QW-1:0] MAX_Q       = '1;
  localparam logic [7:0]    START_LOAD  = 8'(START_CYCLES - 1);
  localparam logic [7:0]    DEPART_LOAD = 8'(DEPART_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    FLOW  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_timer;
  logic [7:0]    w_timer_nxt;
  logic          w_dep_req;
  logic          w_green;
  logic          w_legal;
  logic          w_has_cars;
  logic [QW-1:0] w_count_nxt;
  logic          w_ovf_set;

  // Decode the farm-road light; anything illegal counts as not-green.
  always_comb begin
    w_green    = (light_farm == 3'b001);
    w_legal    = (light_farm == 3'b100) || (light_farm == 3'b010) || (light_farm == 3'b001);
    w_has_cars = (queue_count != '0);
  end

  // Departure FSM next state, down-timer and departure request.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_dep_req   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_green) begin
          w_state_nxt = START;
          w_timer_nxt = START_LOAD;
        end
      end
      START: begin
        if (!w_green) begin
          w_state_nxt = IDLE;
          w_timer_nxt = 8'd0;
        end else if (r_timer == 8'd0) begin
          w_state_nxt = FLOW;
          if (w_has_cars) begin
            w_dep_req   = 1'b1;
            w_timer_nxt = DEPART_LOAD;
          end else begin
            w_timer_nxt = 8'd0;
          end
        end else begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      FLOW: begin
        if (!w_green) begin
          w_state_nxt = IDLE;
          w_timer_nxt = 8'd0;
        end else if (!w_has_cars) begin
          // Park the timer so a newly counted car waits a full departure gap.
          w_timer_nxt = DEPART_LOAD;
        end else if (r_timer == 8'd0) begin
          w_dep_req   = 1'b1;
          w_timer_nxt = DEPART_LOAD;
        end else begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = 8'd0;
      end
    endcase
  end

  // Queue count update; simultaneous arrival and departure cancel out.
  always_comb begin
    w_count_nxt = queue_count;
    w_ovf_set   = 1'b0;
    case ({car_arrive, w_dep_req})
      2'b10: begin
        if (queue_count == MAX_Q) begin
          w_ovf_set = 1'b1;
        end else begin
          w_count_nxt = queue_count + QW'(1);
        end
      end
      2'b01:   w_count_nxt = queue_count - QW'(1);
      default: w_count_nxt = queue_count;
    endcase
  end

  // FSM state and timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Registered outputs; C tracks the next count so it matches queue_count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      queue_count <= '0;
      C           <= 1'b0;
      car_depart  <= 1'b0;
      overflow    <= 1'b0;
      light_err   <= 1'b0;
    end else begin
      queue_count <= w_count_nxt;
      C           <= (w_count_nxt != '0);
      car_depart  <= w_dep_req;
      if (w_ovf_set) overflow  <= 1'b1;
      if (!w_legal)  light_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_farm_road_vehicle_sensor.sv
// Bench for farm_road_vehicle_sensor: directed stimulus with a departure
// scoreboard checked by an independent monitor.
module tb_farm_road_vehicle_sensor;

  logic       clk;
  logic       rst;
  logic       car_arrive;
  logic [2:0] light_farm;
  logic       C;
  logic [3:0] queue_count;
  logic       car_depart;
  logic       overflow;
  logic       light_err;

  typedef struct {
    int edge_n;
    int qc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ecnt    = 0;

  farm_road_vehicle_sensor #(
    .QW(4), .START_CYCLES(4), .DEPART_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .car_arrive(car_arrive), .light_farm(light_farm),
    .C(C), .queue_count(queue_count), .car_depart(car_depart),
    .overflow(overflow), .light_err(light_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp_v, ecnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dep(input int edge_n, input int qc);
    exp_t e;
    e.edge_n = edge_n;
    e.qc     = qc;
    sb.push_back(e);
  endtask

  // Monitor: every departure pulse must match the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (car_depart === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_depart", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("depart_edge", ecnt, e.edge_n);
          chk("depart_qc", int'(queue_count), e.qc);
          chk("depart_C", int'(C), (e.qc != 0) ? 1 : 0);
        end
      end
    end
  end

  initial begin
    int e;
    rst        = 1'b1;
    car_arrive = 1'b0;
    light_farm = 3'b100;

    // 1: reset then idle
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_qc", int'(queue_count), 0);
    chk("rst_C", int'(C), 0);
    chk("rst_depart", int'(car_depart), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_light_err", int'(light_err), 0);

    // 2: three arrivals on red, then long red/yellow with no departures
    for (int i = 0; i < 3; i++) begin
      car_arrive = 1'b1;
      tick();
      chk("arr_qc", int'(queue_count), i + 1);
      chk("arr_C", int'(C), 1);
    end
    car_arrive = 1'b0;
    repeat (50) tick();
    light_farm = 3'b010;
    repeat (50) tick();
    light_farm = 3'b100;
    tick();
    chk("hold_qc", int'(queue_count), 3);

    // 3: drain three cars: departures at G+4, G+6, G+8
    e = ecnt;
    push_dep(e + 5, 2);
    push_dep(e + 7, 1);
    push_dep(e + 9, 0);
    light_farm = 3'b001;
    repeat (12) tick();
    chk("drain_qc", int'(queue_count), 0);
    chk("drain_C", int'(C), 0);
    chk("drain_sb_empty", sb.size(), 0);
    light_farm = 3'b100;
    repeat (2) tick();

    // 4: green cut short after 6 cycles -> one departure
    car_arrive = 1'b1;
    repeat (5) tick();
    car_arrive = 1'b0;
    chk("q5_qc", int'(queue_count), 5);
    e = ecnt;
    push_dep(e + 5, 4);
    light_farm = 3'b001;
    repeat (6) tick();
    light_farm = 3'b010;
    repeat (6) tick();
    chk("cut_qc", int'(queue_count), 4);
    chk("cut_C", int'(C), 1);
    chk("cut_sb_empty", sb.size(), 0);
    light_farm = 3'b100;
    tick();
    // next green restarts the full start delay
    e = ecnt;
    push_dep(e + 5, 3);
    light_farm = 3'b001;
    repeat (5) tick();
    light_farm = 3'b100;
    repeat (3) tick();
    chk("restart_qc", int'(queue_count), 3);
    chk("restart_sb_empty", sb.size(), 0);

    // 5: saturation, then arrival coincident with a departure
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst2_qc", int'(queue_count), 0);
    for (int i = 0; i < 16; i++) begin
      car_arrive = 1'b1;
      tick();
      chk("sat_qc", int'(queue_count), (i + 1 > 15) ? 15 : i + 1);
      chk("sat_overflow", int'(overflow), (i == 15) ? 1 : 0);
    end
    car_arrive = 1'b0;
    e = ecnt;
    push_dep(e + 5, 15);
    light_farm = 3'b001;
    repeat (4) tick();
    car_arrive = 1'b1;
    tick();
    car_arrive = 1'b0;
    light_farm = 3'b100;
    chk("simul_depart", int'(car_depart), 1);
    chk("simul_qc", int'(queue_count), 15);
    repeat (2) tick();
    chk("simul_sb_empty", sb.size(), 0);

    // 6: illegal light code, then async reset mid-drain
    light_farm = 3'b011;
    tick();
    chk("illegal_err", int'(light_err), 1);
    light_farm = 3'b100;
    repeat (3) tick();
    chk("illegal_qc", int'(queue_count), 15);
    e = ecnt;
    push_dep(e + 5, 14);
    light_farm = 3'b001;
    repeat (6) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_qc", int'(queue_count), 0);
    chk("async_C", int'(C), 0);
    chk("async_depart", int'(car_depart), 0);
    chk("async_overflow", int'(overflow), 0);
    chk("async_light_err", int'(light_err), 0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("post_rst_qc", int'(queue_count), 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
